// File: rtl/motion_key_pkg.sv
// Shared types and helpers for the key-to-motion command generator.
// Holds the per-axis FSM states, resolved directions and counter sizing.
package motion_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_PULSE  = 3'd3,
        ST_REPEAT = 3'd4
    } axis_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEG  = 2'd1,
        DIR_POS  = 2'd2
    } dir_t;

    function automatic int cnt_width(input int deb, input int dly, input int per);
        int m;
        m = deb;
        if (dly > m) m = dly;
        if (per > m) m = per;
        return $clog2(m + 1);
    endfunction

    function automatic dir_t resolve_dir(input logic neg, input logic pos);
        dir_t d;
        case ({pos, neg})
            2'b01:   d = DIR_NEG;
            2'b10:   d = DIR_POS;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] dir_mask(input dir_t d);
        logic [1:0] m;
        case (d)
            DIR_NEG: m = 2'b01;
            DIR_POS: m = 2'b10;
            default: m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/axis_key_channel.sv
// One axis: synchronise and debounce both keys, resolve the pair, and drive
// the two command bits in level or pulse/auto-repeat mode.
module axis_key_channel
    import motion_key_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key,
    input  logic [1:0] en,
    input  logic       mode,
    output logic [1:0] cmd
);

    localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] ZERO        = CW'(0);
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] DEB_MAX     = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    filt_r;
    logic [CW-1:0] deb_cnt_r [2];

    axis_state_t   state_r;
    axis_state_t   state_nxt_s;
    dir_t          dir_r;
    dir_t          dir_nxt_s;
    dir_t          dir_s;
    logic [CW-1:0] timer_r;
    logic [CW-1:0] timer_nxt_s;
    logic          mode_r;
    logic [1:0]    cmd_r;
    logic [1:0]    cmd_nxt_s;

    // Two-flop synchroniser for the raw key levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: the filtered level flips only once the counter has already reached DEB_CYCLES
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_r <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt_r[i] <= ZERO;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    deb_cnt_r[i] <= ZERO;
                end else if (deb_cnt_r[i] == DEB_MAX) begin
                    filt_r[i]    <= sync2_r[i];
                    deb_cnt_r[i] <= ZERO;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + ONE;
                end
            end
        end
    end

    assign dir_s = resolve_dir(filt_r[0], filt_r[1]);

    // Next-state logic; pulses are issued on the edge that enters FIRST or PULSE
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        timer_nxt_s = timer_r;
        cmd_nxt_s   = 2'b00;
        if (mode != mode_r) begin
            state_nxt_s = ST_IDLE;
            dir_nxt_s   = DIR_NONE;
        end else if (!mode) begin
            state_nxt_s = ST_IDLE;
            dir_nxt_s   = DIR_NONE;
            cmd_nxt_s   = dir_mask(dir_s) & en;
        end else if (dir_s == DIR_NONE) begin
            state_nxt_s = ST_IDLE;
            dir_nxt_s   = DIR_NONE;
        end else if ((state_r == ST_IDLE) || (dir_s != dir_r)) begin
            state_nxt_s = ST_FIRST;
            dir_nxt_s   = dir_s;
            timer_nxt_s = DELAY_LOAD;
            cmd_nxt_s   = dir_mask(dir_s) & en;
        end else begin
            case (state_r)
                ST_FIRST: begin
                    state_nxt_s = ST_DELAY;
                    timer_nxt_s = timer_r - ONE;
                end
                ST_PULSE: begin
                    state_nxt_s = ST_REPEAT;
                    timer_nxt_s = timer_r - ONE;
                end
                ST_DELAY, ST_REPEAT: begin
                    if (timer_r == ZERO) begin
                        state_nxt_s = ST_PULSE;
                        timer_nxt_s = PERIOD_LOAD;
                        cmd_nxt_s   = dir_mask(dir_r) & en;
                    end else begin
                        timer_nxt_s = timer_r - ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    dir_nxt_s   = DIR_NONE;
                end
            endcase
        end
    end

    // FSM, timer, mode history and command register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            dir_r   <= DIR_NONE;
            timer_r <= ZERO;
            mode_r  <= 1'b0;
            cmd_r   <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            dir_r   <= dir_nxt_s;
            timer_r <= timer_nxt_s;
            mode_r  <= mode;
            cmd_r   <= cmd_nxt_s;
        end
    end

    assign cmd = cmd_r;

endmodule

// File: rtl/motion_key_ctrl.sv
// Key-to-motion command generator: one independent channel per axis,
// bits 2a/2a+1 of key/en/cmd belong to axis a (negative/positive).
module motion_key_ctrl
    import motion_key_pkg::*;
#(
    parameter int N_AXIS        = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*N_AXIS-1:0] key,
    input  logic [2*N_AXIS-1:0] en,
    input  logic [N_AXIS-1:0]   mode,
    output logic [2*N_AXIS-1:0] cmd
);

    for (genvar a = 0; a < N_AXIS; a++) begin : g_axis
        axis_key_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk  (clk),
            .rst  (rst),
            .key  (key[2*a +: 2]),
            .en   (en[2*a +: 2]),
            .mode (mode[a]),
            .cmd  (cmd[2*a +: 2])
        );
    end

endmodule

// File: doc/motion_key_ctrl.md
# motion_key_ctrl

Parametrised key-to-motion command generator for the tracer front end. It takes N_AXIS pairs of opposing raw push-button keys. Each key is synchronised and debounced, and opposing keys on the same axis are resolved against each other. The result is emitted as per-direction command bits, gated by per-direction enables, in either level mode or pulse-with-auto-repeat mode selected per axis. Its outputs drive the motion/rotation datapath directly.

## Interface
- N_AXIS, 2, number of axes; axis a owns key/en/cmd bits 2a (negative direction) and 2a+1 (positive direction)
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a key change (≥1)
- REPEAT_DELAY, 64, cycles from first pulse to first repeat pulse (≥2)
- REPEAT_PERIOD, 16, cycles between subsequent repeat pulses (≥2)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- key  in  2*N_AXIS  raw key levels, active-high, asynchronous to clk
- en  in  2*N_AXIS  per-direction enable, synchronous
- mode  in  N_AXIS  per-axis mode: 0 = level, 1 = pulse/auto-repeat
- cmd  out  2*N_AXIS  registered command bits, one per direction

## Operation
- Sync: each key bit passes through a 2-flop synchroniser.
- Debounce: each key has a filtered state (reset 0) and a counter.
  - The counter increments while the synchronised value differs from the filtered state and clears when they match.
  - When the counter reaches DEB_CYCLES, the filtered state takes the synchronised value and the counter clears.
- Resolve per axis, from the filtered bits neg/pos:
  - exactly one set → direction = that key
  - none set or both set → direction = NONE
- Level mode: cmd[d] = (resolved direction == d) & en[d], registered.
- Pulse mode FSM per axis:
  - IDLE: direction != NONE → FIRST.
  - FIRST: cmd[dir] = en[dir] for one cycle; timer loads REPEAT_DELAY-1 → DELAY.
  - DELAY: timer counts down; at 0 → PULSE.
  - PULSE: cmd[dir] = en[dir] for one cycle; timer loads REPEAT_PERIOD-1 → REPEAT.
  - REPEAT: timer counts down; at 0 → PULSE.
  - Any state: direction becomes NONE → IDLE. Direction flips neg↔pos → FIRST with the new direction.
- en low only masks cmd. It does not stop or reset the FSM or timers; a pulse that falls while en is low is lost.
- A change of mode[a] forces axis a to IDLE and clears its cmd bits on the next edge. The new mode takes effect from the following cycle.
- Axes are fully independent; no cross-axis arbitration.

## Timing
- Reset (rst low, asynchronous): cmd = 0, all filtered states = 0, counters = 0, FSMs = IDLE, synchronisers = 0.
- Latency from the first clk edge sampling a new stable key level to the cmd change:
  - level mode: DEB_CYCLES+3 cycles
  - pulse mode: DEB_CYCLES+3 cycles to the FIRST pulse
- A key glitch shorter than DEB_CYCLES cycles at the synchroniser output never changes cmd.
- In pulse mode, with the first pulse at cycle T, pulses occur at T, T+REPEAT_DELAY, then T+REPEAT_DELAY+k·REPEAT_PERIOD. Each pulse is exactly one cycle wide.
- en toggles take effect on cmd one cycle later (registered).
- Reset asserted mid-repeat clears everything immediately. After release, a still-held key needs the full debounce again.
- Counter width = clog2(max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). There is no wrap: counters saturate or reload by design.

## Structure
- Package motion_key_pkg:
  - axis FSM state enum (IDLE, FIRST, DELAY, PULSE, REPEAT)
  - direction enum (NONE, NEG, POS)
  - counter-width function
- Sub-module axis_key_channel: one axis (2 synchronisers, 2 debouncers, resolver, FSM, timer, cmd register). The top generates N_AXIS instances.

## Test plan
Bench parameters: N_AXIS=2, DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, all en=1.

1. Reset release with all keys 0 → cmd = 4'b0000 for 50 cycles.
2. Level mode:
   - key[1] held → cmd[1] rises 7 cycles after the first sampling edge.
   - A 3-cycle glitch on key[0] → cmd[0] stays 0.
3. Opposing keys, level mode: key[3:2]=11 after debounce → cmd[3:2]=00. Release key[2] → cmd[3:2]=10 after 7 cycles.
4. Pulse mode, key[0] held 30 cycles after the first pulse at T → cmd[0] pulses at T, T+8, T+11, T+14, …, each 1 cycle wide. Release → no further pulses.
5. Pulse mode, en[0] low during T+8 → that pulse is absent and the T+11 pulse is still present.
6. Reset asserted mid-repeat, key held → cmd=0 immediately. After release, the first pulse appears 7 cycles after the first sampling edge.
